crossbar_port_sched: RTL and testbench
======================================

# crossbar_port_sched

Per-output-port scheduler for the switch-core crossbar; it is the requester/consumer side of the round-robin arbiter. It gathers frame-ready requests from the 10 input queues and issues a single-cycle request vector to the arbiter. It takes the one-hot grant back, then switches the granted input's stream onto the output port until that frame's last beat. It re-arbitrates only between frames, so frames are never interleaved.

## Interface
- PORT_NUM, 10, number of input ports; fixed to the arbiter width.
- DATA_WIDTH, 64, stream data width per port.
- WDOG_CYCLES, 1024, number of consecutive stalled XFER cycles before an abort.
- i_sys_clk  in  1  single clock for the whole block.
- i_sys_rst  in  1  asynchronous, active-low reset.
- i_port_req  in  PORT_NUM  bit k high = input k holds at least one complete frame.
- i_port_data  in  PORT_NUM*DATA_WIDTH  per-port data, port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_port_valid  in  PORT_NUM  per-port beat valid.
- i_port_last  in  PORT_NUM  per-port last beat of frame.
- o_port_ready  out  PORT_NUM  per-port ready; only the granted bit can be high.
- o_arb_req_data  out  10  request vector to the arbiter.
- o_arb_req_valid  out  1  single-cycle request strobe to the arbiter.
- i_arb_result  in  10  grant from the arbiter.
- i_arb_result_valid  in  1  grant valid.
- o_data  out  DATA_WIDTH  output stream data.
- o_valid  out  1  output beat valid.
- o_last  out  1  output last beat.
- i_ready  in  1  downstream ready.
- o_grant  out  PORT_NUM  current one-hot grant; 0 outside XFER.
- o_grant_err  out  1  one-cycle pulse when a grant is rejected.
- o_xfer_abort  out  1  one-cycle pulse when the watchdog aborts a frame.

## Operation
- FSM states: IDLE, REQ, WAIT, XFER.
- IDLE: if i_port_req != 0, register it into o_arb_req_data and go to REQ.
- REQ: o_arb_req_valid=1 for exactly this cycle, then go to WAIT.
  - The arbiter advances its pointer only on a rising edge of valid. The FSM guarantees valid is low for at least 2 cycles between strobes.
- WAIT: wait for i_arb_result_valid, then check the grant.
  - A grant is accepted only if it is one-hot and a subset of the latched o_arb_req_data. On accept, latch it into r_grant and go to XFER.
  - On reject (zero, multi-hot, or not requested), pulse o_grant_err and go to IDLE.
  - If i_arb_result_valid does not arrive within 4 cycles, treat it as a reject.
- XFER: pure combinational pass-through of the granted port.
  - o_data and o_last come from the granted port.
  - o_valid = i_port_valid[g].
  - o_port_ready = r_grant & {PORT_NUM{i_ready}}.
  - A beat transfers when o_valid & i_ready.
  - A beat with o_last transferring returns the FSM to IDLE next cycle and clears r_grant.
- Watchdog: a counter of consecutive XFER cycles with no beat transfer; it resets on every beat.
  - When it reaches WDOG_CYCLES-1: pulse o_xfer_abort, clear the grant, go to IDLE.
  - An aborted frame's remaining beats are not drained by this block.
- Requests are sampled only in IDLE. Changes to i_port_req during REQ/WAIT/XFER are ignored until the next IDLE.
- Reset (asynchronous, any state): state=IDLE and every output 0, including o_arb_req_data, o_arb_req_valid, o_grant, o_port_ready, o_valid, o_grant_err, o_xfer_abort and the watchdog counter.
- On release, the first request takes a fresh REQ pulse.

## Timing
- Cycle 0: IDLE sees i_port_req != 0.
- Cycle 1: REQ, o_arb_req_valid=1.
- Cycle 2: the arbiter's registered result is valid; WAIT accepts it.
- Cycle 3: XFER, first beat possible.
- Request-to-first-beat latency is 3 cycles.
- After the last beat handshakes in cycle n: IDLE in n+1, REQ in n+2. The minimum inter-frame gap is 3 idle output cycles.
- In XFER, o_valid/o_data/o_port_ready have zero latency from their inputs, with no buffering.
- o_grant_err and o_xfer_abort are registered one-cycle pulses.

## Structure
- Shared package crossbar_pkg: PORT_NUM=10, state encoding (IDLE=0, REQ=1, WAIT=2, XFER=3), WAIT_TIMEOUT=4.
- One sub-module, crossbar_onehot_check: combinational check that a grant is one-hot and a subset of the request.
- The mux is a reduction OR of r_grant-masked port data, kept inline.

## Test plan
- Single requester, i_port_req=10'h004, 3-beat frame, i_ready=1: o_arb_req_valid pulses in cycle 1, o_grant=10'h004 from cycle 3, 3 beats out, o_last on beat 3, IDLE after.
- All ports request continuously, each sending 1-beat frames, with a model arbiter: grants rotate through every port over 10 frames, exactly one REQ pulse per frame, and valid stays low at least 2 cycles between pulses.
- Stub arbiter returns 10'h003 for request 10'h003: o_grant_err pulses once, no o_port_ready is asserted, FSM back in IDLE.
- i_ready toggles 1,0,0,1 mid-frame: no beat is lost or duplicated, and o_port_ready[g] follows i_ready exactly.
- Granted port stalls with i_port_valid=0 for WDOG_CYCLES cycles: o_xfer_abort pulses once, o_grant becomes 0, and the next request is arbitrated.
- Assert i_sys_rst low mid-XFER: all outputs 0 immediately (asynchronous). After release with i_port_req=10'h200, a full 3-cycle REQ/WAIT sequence precedes the first beat.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar output-port scheduler: port count,
// FSM state encoding and the arbiter response timeout.
package crossbar_pkg;
    localparam int PORT_NUM     = 10;
    localparam int WAIT_TIMEOUT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_XFER = 2'd3
    } state_t;
endpackage

// File: rtl/crossbar_port_sched_if.sv
// Bundle of input-queue, arbiter and output-stream signals for one scheduler.
// Streams use valid/ready: a beat moves on a clock edge where both are high;
// a source holds data/last stable while valid is high and ready is low.
interface crossbar_port_sched_if
    import crossbar_pkg::*;
#(
    parameter int DATA_WIDTH = 64
);
    logic [PORT_NUM-1:0]            i_port_req;
    logic [PORT_NUM*DATA_WIDTH-1:0] i_port_data;
    logic [PORT_NUM-1:0]            i_port_valid;
    logic [PORT_NUM-1:0]            i_port_last;
    logic [PORT_NUM-1:0]            o_port_ready;
    logic [PORT_NUM-1:0]            o_arb_req_data;
    logic                           o_arb_req_valid;
    logic [PORT_NUM-1:0]            i_arb_result;
    logic                           i_arb_result_valid;
    logic [DATA_WIDTH-1:0]          o_data;
    logic                           o_valid;
    logic                           o_last;
    logic                           i_ready;
    logic [PORT_NUM-1:0]            o_grant;
    logic                           o_grant_err;
    logic                           o_xfer_abort;
    state_t                         dbg_state;

    modport master (
        output i_port_req, i_port_data, i_port_valid, i_port_last,
        output i_arb_result, i_arb_result_valid, i_ready,
        input  o_port_ready, o_arb_req_data, o_arb_req_valid,
        input  o_data, o_valid, o_last, o_grant, o_grant_err, o_xfer_abort,
        input  dbg_state
    );

    modport slave (
        input  i_port_req, i_port_data, i_port_valid, i_port_last,
        input  i_arb_result, i_arb_result_valid, i_ready,
        output o_port_ready, o_arb_req_data, o_arb_req_valid,
        output o_data, o_valid, o_last, o_grant, o_grant_err, o_xfer_abort,
        output dbg_state
    );
endinterface

// File: rtl/crossbar_onehot_check.sv
// Grant qualification: the arbiter result must be exactly one bit and that
// bit must have been part of the request vector we sent.
module crossbar_onehot_check
    import crossbar_pkg::*;
(
    input  logic [PORT_NUM-1:0] i_req,
    input  logic [PORT_NUM-1:0] i_grant,
    output logic                o_ok
);
    logic one_hot;
    logic subset;

    always_comb begin
        one_hot = (i_grant != '0) && ((i_grant & (i_grant - PORT_NUM'(1))) == '0);
        subset  = (i_grant & ~i_req) == '0;
        o_ok    = one_hot && subset;
    end
endmodule

// File: rtl/crossbar_port_sched.sv
// Per-output-port scheduler: requests arbitration between frames, then
// passes the granted input stream straight through until its last beat.
module crossbar_port_sched
    import crossbar_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    crossbar_port_sched_if.slave  bus
);
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int WAIT_W = $clog2(WAIT_TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [PORT_NUM-1:0]   req_data_q, req_data_d;
    logic [PORT_NUM-1:0]   grant_q, grant_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  grant_err_q, grant_err_d;
    logic                  abort_q, abort_d;
    logic                  grant_ok;
    logic                  in_xfer;
    logic                  out_valid;
    logic                  out_last;
    logic                  beat;
    logic [DATA_WIDTH-1:0] mux_data;

    crossbar_onehot_check u_onehot_check (
        .i_req   (req_data_q),
        .i_grant (bus.i_arb_result),
        .o_ok    (grant_ok)
    );

    // grant_q is zero outside XFER, so the masked OR also yields zero there.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            mux_data |= bus.i_port_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[k]}};
        end
    end

    assign in_xfer   = (state_q == ST_XFER);
    assign out_valid = in_xfer & |(grant_q & bus.i_port_valid);
    assign out_last  = in_xfer & |(grant_q & bus.i_port_last);
    assign beat      = out_valid & bus.i_ready;

    assign bus.o_data          = mux_data;
    assign bus.o_valid         = out_valid;
    assign bus.o_last          = out_last;
    assign bus.o_port_ready    = in_xfer ? (grant_q & {PORT_NUM{bus.i_ready}}) : '0;
    assign bus.o_grant         = grant_q;
    assign bus.o_arb_req_data  = req_data_q;
    assign bus.o_arb_req_valid = (state_q == ST_REQ);
    assign bus.o_grant_err     = grant_err_q;
    assign bus.o_xfer_abort    = abort_q;
    assign bus.dbg_state       = state_q;

    always_comb begin
        state_d     = state_q;
        req_data_d  = req_data_q;
        grant_d     = grant_q;
        wait_cnt_d  = wait_cnt_q;
        wdog_d      = wdog_q;
        grant_err_d = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                wdog_d     = '0;
                if (bus.i_port_req != '0) begin
                    req_data_d = bus.i_port_req;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.i_arb_result_valid) begin
                    if (grant_ok) begin
                        grant_d = bus.i_arb_result;
                        wdog_d  = '0;
                        state_d = ST_XFER;
                    end else begin
                        grant_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // A missing arbiter response is handled like a bad grant.
                    grant_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_XFER: begin
                if (beat && out_last) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else if (beat) begin
                    wdog_d = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    // Remaining beats of the aborted frame stay in the source queue.
                    abort_d = 1'b1;
                    grant_d = '0;
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q     <= ST_IDLE;
            req_data_q  <= '0;
            grant_q     <= '0;
            wait_cnt_q  <= '0;
            wdog_q      <= '0;
            grant_err_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_data_q  <= req_data_d;
            grant_q     <= grant_d;
            wait_cnt_q  <= wait_cnt_d;
            wdog_q      <= wdog_d;
            grant_err_q <= grant_err_d;
            abort_q     <= abort_d;
        end
    end
endmodule

// File: tb/tb_crossbar_port_sched.sv
// Bench for crossbar_port_sched: environment arbiter, directed sequences,
// a grant-qualification vector table and a randomized multi-port run.
module tb_crossbar_port_sched;
  import crossbar_pkg::*;

  localparam int DW   = 64;
  localparam int WDOG = 1024;
  localparam int NP   = PORT_NUM;

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] res;
    int            lat;
    logic [NP-1:0] exp_grant;
    logic          exp_err;
    int            exp_cycle;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // environment arbiter controls (main writes, arbiter reads)
  int            arb_mode = 0;
  logic [NP-1:0] stub_res = '0;
  int            arb_lat  = 0;
  // environment arbiter state (arbiter writes, main reads)
  int            arb_ptr      = 0;
  int            n_req_pulses = 0;

  vec_t          vecs [9];
  logic          rdy_pat [8];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   src_q [NP][$];
  logic [DW:0]   mdl_q [NP][$];

  always #5 clk = ~clk;

  crossbar_port_sched_if #(.DATA_WIDTH(DW)) bus ();

  crossbar_port_sched #(.DATA_WIDTH(DW), .WDOG_CYCLES(WDOG)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bus       (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NP-1:0] req, input int ptr);
    for (int i = 0; i < NP; i++) begin
      if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] pat(input int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k * 17 + 3);
  endfunction

  task automatic set_port(input int k, input logic [DW-1:0] d, input logic v, input logic l);
    bus.i_port_data[k*DW +: DW] = d;
    bus.i_port_valid[k] = v;
    bus.i_port_last[k]  = l;
  endtask

  task automatic idle_inputs();
    bus.i_port_req   = '0;
    bus.i_port_data  = '0;
    bus.i_port_valid = '0;
    bus.i_port_last  = '0;
    bus.i_ready      = 1'b0;
  endtask

  // Environment arbiter: responds to each rising edge of the request strobe
  // with a registered grant, arb_lat cycles later than the earliest slot.
  initial begin
    logic          prev_v;
    logic          pend;
    int            cd;
    int            g;
    int            gap_cnt;
    logic [NP-1:0] pgrant;
    bus.i_arb_result       = '0;
    bus.i_arb_result_valid = 1'b0;
    prev_v = 1'b0; pend = 1'b0; cd = 0; gap_cnt = 100; pgrant = '0;
    forever begin
      @(negedge clk);
      bus.i_arb_result_valid = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          bus.i_arb_result_valid = 1'b1;
          bus.i_arb_result       = pgrant;
          pend = 1'b0;
        end else begin
          cd--;
        end
      end
      if (bus.o_arb_req_valid && !prev_v) begin
        check("req_gap_ge2", gap_cnt >= 2, 1'b1);
        gap_cnt = 0;
        n_req_pulses++;
        if (arb_mode == 0) begin
          g = rr_pick(bus.o_arb_req_data, arb_ptr);
          if (g >= 0) begin
            pgrant  = NP'(1) << g;
            arb_ptr = (g + 1) % NP;
          end else begin
            pgrant = '0;
          end
        end else begin
          pgrant = stub_res;
        end
        pend = 1'b1;
        cd   = arb_lat;
      end else if (!bus.o_arb_req_valid) begin
        gap_cnt++;
      end
      prev_v = bus.o_arb_req_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int err_cnt, err_cyc, g_cyc, n, nb, cyc, start_ptr, pulses0, src_idx, total, g, nf, len;
    logic [NP-1:0] g_val, mask;
    logic          leak, aborted, multi;
    logic [DW:0]   e;
    logic [DW-1:0] d;

    vecs[0] = '{10'h004, 10'h004, 0, 10'h004, 1'b0, 3};
    vecs[1] = '{10'h003, 10'h003, 0, 10'h000, 1'b1, 3};
    vecs[2] = '{10'h003, 10'h000, 0, 10'h000, 1'b1, 3};
    vecs[3] = '{10'h00C, 10'h010, 0, 10'h000, 1'b1, 3};
    vecs[4] = '{10'h3FF, 10'h080, 0, 10'h080, 1'b0, 3};
    vecs[5] = '{10'h101, 10'h100, 3, 10'h100, 1'b0, 6};
    vecs[6] = '{10'h050, 10'h040, 4, 10'h000, 1'b1, 6};
    vecs[7] = '{10'h200, 10'h200, 1, 10'h200, 1'b0, 4};
    vecs[8] = '{10'h081, 10'h081, 2, 10'h000, 1'b1, 5};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // ---------------- reset ----------------
    idle_inputs();
    bus.i_port_req = 10'h3FF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", bus.dbg_state, ST_IDLE);
    check("rst_grant", bus.o_grant, 0);
    check("rst_req_valid", bus.o_arb_req_valid, 0);
    check("rst_req_data", bus.o_arb_req_data, 0);
    check("rst_port_ready", bus.o_port_ready, 0);
    check("rst_err_abort", {bus.o_grant_err, bus.o_xfer_abort, bus.o_valid}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- single requester, 3-beat frame ----------------
    arb_mode = 0; arb_lat = 0;
    @(negedge clk);
    bus.i_ready = 1'b1;
    bus.i_port_req = 10'h004;
    set_port(2, 64'h1111_0000_0000_0000, 1'b1, 1'b0);
    #1 check("t1_idle_ovalid", bus.o_valid, 0);
    @(negedge clk); #1;
    check("t1_req_pulse", bus.o_arb_req_valid, 1);
    check("t1_req_data", bus.o_arb_req_data, 10'h004);
    bus.i_port_req = '0;
    @(negedge clk); #1;
    check("t1_wait_strobe_low", bus.o_arb_req_valid, 0);
    check("t1_wait_grant", bus.o_grant, 0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      set_port(2, 64'h1111_0000_0000_0000 + 64'(b), 1'b1, b == 2);
      #1;
      check("t1_grant", bus.o_grant, 10'h004);
      check("t1_port_ready", bus.o_port_ready, 10'h004);
      check("t1_beat", {bus.o_valid, bus.o_last, bus.o_data},
            {1'b1, b == 2, 64'h1111_0000_0000_0000 + 64'(b)});
    end
    @(negedge clk);
    set_port(2, '0, 1'b0, 1'b0);
    #1;
    check("t1_after_grant", bus.o_grant, 0);
    check("t1_after_state", bus.dbg_state, ST_IDLE);

    // ---------------- all ports, 1-beat frames, round robin ----------------
    @(negedge clk);
    for (int k = 0; k < NP; k++) set_port(k, pat(k), 1'b1, 1'b1);
    bus.i_port_req = 10'h3FF;
    start_ptr = arb_ptr;
    pulses0   = n_req_pulses;
    nb = 0; cyc = 0;
    while (nb < 10 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (bus.o_valid && bus.i_ready) begin
        g = (start_ptr + nb) % NP;
        check("t2_grant", bus.o_grant, NP'(1) << g);
        check("t2_data", bus.o_data, pat(g));
        nb++;
        if (nb == 10) bus.i_port_req = '0;
      end
    end
    check("t2_frames", nb, 10);
    repeat (3) @(negedge clk);
    check("t2_req_pulses", n_req_pulses - pulses0, 10);
    idle_inputs();

    // ---------------- grant qualification table ----------------
    arb_mode = 1;
    foreach (vecs[i]) begin
      stub_res = vecs[i].res;
      arb_lat  = vecs[i].lat;
      @(negedge clk);
      bus.i_ready    = 1'b1;
      bus.i_port_req = vecs[i].req;
      err_cnt = 0; err_cyc = -1; g_cyc = -1; g_val = '0; leak = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk); #1;
        if (c == 1) begin
          check("tv_req_pulse", bus.o_arb_req_valid, 1);
          bus.i_port_req = '0;
        end
        if (bus.o_grant_err) begin
          err_cnt++;
          if (err_cyc < 0) err_cyc = c;
        end
        if (bus.o_grant != '0 && g_cyc < 0) begin
          g_cyc = c;
          g_val = bus.o_grant;
          bus.i_port_valid = '1;
          bus.i_port_last  = '1;
        end
        if (vecs[i].exp_grant == '0 && bus.o_port_ready != '0) leak = 1'b1;
      end
      idle_inputs();
      check("tv_grant", g_val, vecs[i].exp_grant);
      check("tv_err_pulses", err_cnt, vecs[i].exp_err ? 1 : 0);
      check("tv_cycle", vecs[i].exp_err ? err_cyc : g_cyc, vecs[i].exp_cycle);
      check("tv_ready_leak", leak, 0);
      check("tv_state_idle", bus.dbg_state, ST_IDLE);
    end
    arb_mode = 0; arb_lat = 0;

    // ---------------- downstream ready toggling mid-frame ----------------
    for (int b = 0; b < 4; b++) exp_q.push_back({b == 3, 64'h5555_0000_0000_0000 + 64'(b)});
    src_idx = 0;
    @(negedge clk);
    bus.i_port_req = 10'h020;
    bus.i_ready    = 1'b1;
    set_port(5, 64'h5555_0000_0000_0000, 1'b1, 1'b0);
    for (int c = 1; c < 20 && src_idx < 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_port_req = '0;
      if (c >= 3) bus.i_ready = (c - 3 < 8) ? rdy_pat[c-3] : 1'b1;
      set_port(5, 64'h5555_0000_0000_0000 + 64'(src_idx), 1'b1, src_idx == 3);
      #1;
      if (c == 3) check("t4_latency", bus.o_grant, 10'h020);
      if (c >= 3) check("t4_port_ready", bus.o_port_ready, bus.i_ready ? 10'h020 : 10'h000);
      if (bus.o_valid && bus.i_ready) begin
        e = exp_q.pop_front();
        check("t4_beat", {bus.o_last, bus.o_data}, e);
        src_idx++;
      end
    end
    check("t4_beats_left", exp_q.size(), 0);
    @(negedge clk);
    set_port(5, '0, 1'b0, 1'b0);
    #1 check("t4_idle", bus.dbg_state, ST_IDLE);

    // ---------------- watchdog abort ----------------
    @(negedge clk);
    bus.i_port_req = 10'h080;
    bus.i_ready    = 1'b1;
    n = 0; aborted = 1'b0;
    for (int c = 0; c < WDOG + 40; c++) begin
      @(negedge clk); #1;
      if (bus.o_xfer_abort) begin
        aborted = 1'b1;
        break;
      end
      if (bus.o_grant == 10'h080) n++;
    end
    check("t5_aborted", aborted, 1);
    check("t5_stall_cycles", n, WDOG);
    check("t5_grant_cleared", bus.o_grant, 0);
    @(negedge clk); #1;
    check("t5_abort_once", bus.o_xfer_abort, 0);
    check("t5_rearb", bus.o_arb_req_valid, 1);
    bus.i_port_req = '0;
    @(negedge clk);
    set_port(7, 64'h7777, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("t5_regrant", {bus.o_grant, bus.o_valid}, {10'h080, 1'b1});
    @(negedge clk); #1;
    check("t5_done", bus.o_grant, 0);
    idle_inputs();

    // ---------------- randomized multi-port frames ----------------
    total = 0;
    for (int k = 0; k < NP; k++) begin
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          d = {$urandom, $urandom};
          src_q[k].push_back({b == len - 1, d});
          mdl_q[k].push_back({b == len - 1, d});
        end
        total++;
      end
    end
    if (total == 0) begin
      src_q[3].push_back({1'b1, 64'hABCD});
      mdl_q[3].push_back({1'b1, 64'hABCD});
    end
    // Reference order: each frame boundary picks round-robin among ports
    // that still hold frames; a frame's beats leave contiguously.
    start_ptr = arb_ptr;
    forever begin
      mask = '0;
      for (int k = 0; k < NP; k++) mask[k] = mdl_q[k].size() > 0;
      if (mask == '0) break;
      g = rr_pick(mask, start_ptr);
      start_ptr = (g + 1) % NP;
      do begin
        e = mdl_q[g].pop_front();
        exp_q.push_back(e);
      end while (!e[DW]);
    end
    multi = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      for (int k = 0; k < NP; k++) begin
        if (src_q[k].size() > 0) begin
          bus.i_port_req[k] = 1'b1;
          set_port(k, src_q[k][0][DW-1:0], $urandom_range(0, 3) != 0, src_q[k][0][DW]);
        end else begin
          bus.i_port_req[k] = 1'b0;
          set_port(k, '0, 1'b0, 1'b0);
        end
      end
      bus.i_ready = $urandom_range(0, 9) < 7;
      #1;
      if ($countones(bus.o_port_ready) > 1) multi = 1'b1;
      if (bus.o_valid && bus.i_ready) begin
        e = exp_q.pop_front();
        check("rnd_beat", {bus.o_last, bus.o_data}, e);
      end
      for (int k = 0; k < NP; k++) begin
        if (bus.o_port_ready[k] && bus.i_port_valid[k]) void'(src_q[k].pop_front());
      end
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_ready_onehot", multi, 0);
    @(negedge clk);
    idle_inputs();

    // ---------------- asynchronous reset mid-XFER ----------------
    repeat (3) @(negedge clk);
    bus.i_ready    = 1'b1;
    bus.i_port_req = 10'h002;
    set_port(1, 64'h2222, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) bus.i_port_req = '0;
    end
    #1 check("t6_in_xfer", bus.o_grant, 10'h002);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_grant", bus.o_grant, 0);
    check("t6_rst_ready", bus.o_port_ready, 0);
    check("t6_rst_outs", {bus.o_valid, bus.o_arb_req_valid, bus.o_grant_err, bus.o_xfer_abort}, 0);
    check("t6_rst_req_data", bus.o_arb_req_data, 0);
    check("t6_rst_state", bus.dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_port(1, '0, 1'b0, 1'b0);
    bus.i_port_req = 10'h200;
    set_port(9, 64'h9999, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("t6_req_pulse", {bus.o_arb_req_valid, bus.o_grant, bus.o_valid}, {1'b1, 10'h000, 1'b0});
    bus.i_port_req = '0;
    @(negedge clk); #1;
    check("t6_wait", {bus.o_arb_req_valid, bus.o_grant, bus.o_valid}, {1'b0, 10'h000, 1'b0});
    @(negedge clk); #1;
    check("t6_first_beat", {bus.o_grant, bus.o_valid, bus.o_data}, {10'h200, 1'b1, 64'h9999});
    @(negedge clk); #1;
    check("t6_back_idle", bus.dbg_state, ST_IDLE);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
